// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: captures the PC, waits WAIT_STATES cycles, returns a ROM word
// (or a fault NOP) as a one-cycle valid pulse, and stalls the PC register while a fetch is pending.
module imem_fetch_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_f,
    input  logic              redirect_e,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       instr_f,
    output logic              instr_valid_f,
    output logic              fetch_fault_f,
    output logic              stall_req_f,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              fault_q;
    logic [31:0]       count_q;
    logic [31:0]       rom [DEPTH_WORDS];

    logic [31:0]       rd_addr;
    logic              rd_fault;
    logic [ADDR_W-1:0] rd_idx;
    logic              enter_done;

    // With zero wait states the IDLE edge already enters DONE, so the read must use pc_f directly.
    always_comb begin
        rd_addr  = (state_q == S_IDLE) ? pc_f : req_addr_q;
        rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= 30'(DEPTH_WORDS));
        rd_idx   = rd_addr[ADDR_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_addr_d = pc_f;
                if (!redirect_e) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (redirect_e) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        stall_req_f = (state_q != S_DONE) && !redirect_e;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_addr_q <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            valid_q    <= enter_done;
            if (enter_done) begin
                instr_q <= rd_fault ? NOP_INSTR : rom[rd_idx];
                fault_q <= rd_fault;
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Separate write process: a same-edge read of the written index sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            rom[load_addr] <= load_data;
        end
    end

    assign instr_f       = instr_q;
    assign instr_valid_f = valid_q;
    assign fetch_fault_f = fault_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: two instances (2 and 0 wait states) checked every cycle against
// a cycles-since-capture model, plus directed literal checks from the test plan.
module tb_imem_fetch_responder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] pc    [2];
    logic        redir [2];
    logic [31:0] instr_o [2];
    logic        valid_o [2];
    logic        fault_o [2];
    logic        stall_o [2];
    logic [31:0] count_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .NOP_INSTR(NOP)) dut0 (
        .clk(clk), .reset(reset), .pc_f(pc[0]), .redirect_e(redir[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instr_f(instr_o[0]), .instr_valid_f(valid_o[0]), .fetch_fault_f(fault_o[0]),
        .stall_req_f(stall_o[0]), .fetch_count(count_o[0])
    );

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .NOP_INSTR(NOP)) dut1 (
        .clk(clk), .reset(reset), .pc_f(pc[1]), .redirect_e(redir[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instr_f(instr_o[1]), .instr_valid_f(valid_o[1]), .fetch_fault_f(fault_o[1]),
        .stall_req_f(stall_o[1]), .fetch_count(count_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mp = cycles elapsed since the address was captured; valid when it reaches WS+1.
    int unsigned ws [2] = '{2, 0};
    int unsigned mp [2];
    logic [31:0] maddr [2];
    logic [31:0] minstr [2];
    logic [31:0] mcnt [2];
    logic        mvalid [2];
    logic        mfault [2];
    logic [31:0] mem [256];
    bit          m_init = 0;

    task automatic model_step(input int k);
        if (reset) begin
            mp[k] = 0; minstr[k] = NOP; mvalid[k] = 0; mfault[k] = 0; mcnt[k] = 0;
        end else if (mp[k] == ws[k] + 1 || redir[k]) begin
            mp[k] = 0; mvalid[k] = 0;
        end else begin
            if (mp[k] == 0) maddr[k] = pc[k];
            mp[k]++;
            mvalid[k] = (mp[k] == ws[k] + 1);
            if (mvalid[k]) begin
                mfault[k] = (maddr[k][1:0] != 2'b00) || (maddr[k][31:2] >= 30'd256);
                minstr[k] = mfault[k] ? NOP : mem[maddr[k][9:2]];
                mcnt[k]   = mcnt[k] + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
            if (load_en) mem[load_addr] = load_data;
            if (reset) m_init = 1;
            #3;
            if (m_init) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("model_valid%0d", k), 32'(valid_o[k]), 32'(mvalid[k]));
                    chk($sformatf("model_instr%0d", k), instr_o[k], minstr[k]);
                    chk($sformatf("model_count%0d", k), count_o[k], mcnt[k]);
                    chk($sformatf("model_stall%0d", k), 32'(stall_o[k]),
                        32'((mp[k] != ws[k] + 1) && !redir[k]));
                    if (mvalid[k])
                        chk($sformatf("model_fault%0d", k), 32'(fault_o[k]), 32'(mfault[k]));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #4;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

    initial begin
        reset = 1; load_en = 0; load_addr = '0; load_data = '0;
        pc[0] = '0; pc[1] = '0; redir[0] = 0; redir[1] = 0;
        for (int i = 0; i < 256; i++) begin
            load_en   = 1;
            load_addr = 8'(i);
            load_data = (i < 4) ? prog[i] : 32'h1000_0000 + 32'(i);
            cyc();
        end
        load_en = 0;
        cyc();
        // cycle 0: reset state
        reset = 0; pc[0] = 32'h0; pc[1] = 32'h4;
        chk("c0_instr0", instr_o[0], NOP);
        chk("c0_valid0", 32'(valid_o[0]), 0);
        chk("c0_count0", count_o[0], 0);
        chk("c0_stall0", 32'(stall_o[0]), 1);
        chk("c0_stall1", 32'(stall_o[1]), 1);
        cyc(); // c1
        chk("c1_stall0", 32'(stall_o[0]), 1);
        chk("c1_valid1", 32'(valid_o[1]), 1);
        chk("c1_instr1", instr_o[1], 32'h00A00113);
        cyc(); // c2
        chk("c2_stall0", 32'(stall_o[0]), 1);
        chk("c2_valid1", 32'(valid_o[1]), 0);
        cyc(); // c3
        chk("c3_stall0", 32'(stall_o[0]), 0);
        chk("c3_valid0", 32'(valid_o[0]), 1);
        chk("c3_instr0", instr_o[0], 32'h00500093);
        chk("c3_valid1", 32'(valid_o[1]), 1);
        pc[0] = 32'h4;
        cycles(4); // c7
        chk("c7_valid0", 32'(valid_o[0]), 1);
        chk("c7_instr0", instr_o[0], 32'h00A00113);
        chk("c7_count0", count_o[0], 2);
        pc[0] = 32'h8;
        cycles(2); // c9: WAIT, abort with redirect to 0xC
        redir[0] = 1; pc[0] = 32'hC;
        #1 chk("c9_redir_stall0", 32'(stall_o[0]), 0);
        cyc(); // c10: back in IDLE
        chk("c10_valid0", 32'(valid_o[0]), 0);
        chk("c10_count0", count_o[0], 2);
        redir[0] = 0; pc[1] = 32'h401;
        #1 chk("c10_stall0", 32'(stall_o[0]), 1);
        cycles(3); // c13
        chk("c13_valid0", 32'(valid_o[0]), 1);
        chk("c13_instr0", instr_o[0], 32'h0000006F);
        chk("c13_count0", count_o[0], 3);
        pc[0] = 32'h2; pc[1] = 32'h4;
        cycles(4); // c17: misaligned fault
        chk("c17_valid0", 32'(valid_o[0]), 1);
        chk("c17_instr0", instr_o[0], NOP);
        chk("c17_fault0", 32'(fault_o[0]), 1);
        pc[0] = 32'h400;
        cycles(4); // c21: out-of-range fault
        chk("c21_valid0", 32'(valid_o[0]), 1);
        chk("c21_instr0", instr_o[0], NOP);
        chk("c21_fault0", 32'(fault_o[0]), 1);
        chk("c21_count0", count_o[0], 5);
        pc[0] = 32'h4;
        cycles(2); // c23: WAIT, reset mid-fetch
        reset = 1;
        cyc(); // R0
        chk("r0_valid0", 32'(valid_o[0]), 0);
        chk("r0_instr0", instr_o[0], NOP);
        chk("r0_count0", count_o[0], 0);
        chk("r0_stall0", 32'(stall_o[0]), 1);
        reset = 0;
        cycles(3); // R3
        chk("r3_valid0", 32'(valid_o[0]), 1);
        chk("r3_instr0", instr_o[0], 32'h00A00113);
        chk("r3_count0", count_o[0], 1);
        pc[0] = 32'h0;
        cycles(3); // R6: write index 0 on the DONE-entry edge
        load_en = 1; load_addr = 8'd0; load_data = 32'hDEADBEEF;
        cyc(); // R7
        load_en = 0;
        chk("rbw_old_instr0", instr_o[0], 32'h00500093);
        chk("rbw_old_valid0", 32'(valid_o[0]), 1);
        cycles(4); // R11
        chk("rbw_new_instr0", instr_o[0], 32'hDEADBEEF);
        chk("rbw_new_count0", count_o[0], 3);
        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Responder end of the instruction-fetch interface.
- Sits between the fetch unit's PC register and a word-addressed instruction ROM.
- Accepts the fetch address, returns the instruction after a configurable number of wait states, and drives the stall request back to the PC register while a fetch is in flight.
- Aborts an in-flight fetch on an execute-stage redirect so the fetch unit can load the branch target.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit ROM words; power of two, ≥ 2.
- WAIT_STATES, 2, extra cycles between address capture and data return; 0..15.
- NOP_INSTR, 32'h00000013, instruction returned on reset and on faults (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_f  in  32  fetch address from the PC register.
- redirect_e  in  1  execute-stage redirect taken (branch/jump); aborts the current fetch.
- load_en  in  1  ROM program-load write enable.
- load_addr  in  log2(DEPTH_WORDS)  ROM word index for the load.
- load_data  in  32  ROM word written when load_en=1.
- instr_f  out  32  fetched instruction (registered).
- instr_valid_f  out  1  instr_f valid; one-cycle pulse.
- fetch_fault_f  out  1  returned instruction is a fault NOP; qualified by instr_valid_f.
- stall_req_f  out  1  hold PC register (feeds the PC enable as ~stall).
- fetch_count  out  32  count of completed (valid) fetches; wraps.

Behaviour:
- Reset (reset=1 at an edge), from any state including mid-fetch:
  - state=IDLE
  - instr_f=NOP_INSTR, instr_valid_f=0, fetch_fault_f=0, fetch_count=0, wait counter=0
  - ROM contents unaffected.
- States: IDLE, WAIT, DONE. Encoding is free.
- IDLE:
  - Latch req_addr<=pc_f.
  - Compute fault: pc_f[1:0]!=0, or pc_f[31:2] ≥ DEPTH_WORDS.
  - If WAIT_STATES=0, go to DONE; else load cnt<=WAIT_STATES and go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt==1, go to DONE at the next edge. WAIT therefore lasts exactly WAIT_STATES cycles.
- On every transition into DONE:
  - instr_f <= fault ? NOP_INSTR : rom[req_addr[ADDR_W+1:2]]
  - fetch_fault_f <= fault
  - instr_valid_f <= 1 (registered, high only while in DONE)
  - fetch_count <= fetch_count+1 (wraps 2^32-1 → 0)
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: address captured in cycle t (IDLE) → instr_valid_f=1 in cycle t+WAIT_STATES+1. Throughput is one instruction per WAIT_STATES+2 cycles.
- stall_req_f (combinational):
  - 1 in IDLE and WAIT; 0 in DONE, so the PC advances on the DONE edge.
  - Forced to 0 whenever redirect_e=1, so the target is loaded.
- Redirect:
  - redirect_e=1 in IDLE or WAIT: next state IDLE, no DONE entry, no count increment, instr_valid_f stays 0.
  - redirect_e=1 in DONE: the valid pulse is still delivered, next state IDLE.
  - Reset has priority over redirect.
- instr_f holds its last value outside DONE; consumers qualify it with instr_valid_f.
- ROM writes:
  - load_en=1 writes rom[load_addr]<=load_data at the edge, in any state.
  - A write on the same edge as the WAIT/IDLE→DONE read of the same index returns the old word (read-before-write).
- pc_f changes while in WAIT are ignored; req_addr is the only address used.
- No X on outputs after the first reset edge.

Test Plan:
- WAIT_STATES=2: load rom[0..3]=0x00500093,0x00A00113,0x002081B3,0x0000006F; reset; pc_f=0 → stall_req_f=1,1,1,0 over cycles 0..3. Cycle 3: instr_valid_f=1, instr_f=0x00500093. With the PC register fed back, the second valid at cycle 7 returns 0x00A00113. fetch_count=2 after cycle 7.
- WAIT_STATES=0: pc_f=4 → DONE at cycle 1, instr_f=0x00A00113, one valid every 2 cycles.
- Redirect in WAIT: pc_f=8; assert redirect_e in cycle 1 → stall_req_f=0 in cycle 1, no valid pulse, IDLE in cycle 2. Next fetch latches the new pc_f; fetch_count unchanged by the aborted fetch.
- Fault: pc_f=0x00000002 → instr_f=0x00000013, fetch_fault_f=1, instr_valid_f=1. Repeat with pc_f=0x00000400 (DEPTH_WORDS=256) → same response.
- Reset mid-fetch: assert reset in WAIT → next cycle state=IDLE, instr_valid_f=0, instr_f=0x00000013, fetch_count=0, stall_req_f=1. ROM still returns preloaded words on the next fetch.
- Read-before-write: load_en to index 0 with 0xDEADBEEF on the DONE-entry edge of a pc_f=0 fetch → instr_f=0x00500093. Next fetch of 0 returns 0xDEADBEEF.
